// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the two common data buses: up to two grants per cycle, registered broadcast.
// Optional macro CDB_ARBITER_STALL_COUNT_EN adds per-requester saturating stall counters.
module cdb_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int XLEN       = 32,
  parameter int REG_BITS   = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           delete_tag,
  input  logic [REQUESTERS-1:0]          req_valid,
  input  logic [REQUESTERS-1:0]          req_tag,
  input  logic [REQUESTERS*REG_BITS-1:0] req_arn,
  input  logic [REQUESTERS*REG_BITS-1:0] req_rrn,
  input  logic [REQUESTERS*XLEN-1:0]     req_result,
  output logic [REQUESTERS-1:0]          req_ready,
  output logic [1:0]                     bus_valid,
  output logic [1:0]                     bus_tag,
  output logic [2*REG_BITS-1:0]          bus_arn,
  output logic [2*REG_BITS-1:0]          bus_rrn,
`ifdef CDB_ARBITER_STALL_COUNT_EN
  output logic [2*XLEN-1:0]              bus_result,
  output logic [REQUESTERS*16-1:0]       stall_count
`else
  output logic [2*XLEN-1:0]              bus_result
`endif
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_nxt_s;
  logic [REQUESTERS-1:0] elig_s;
  logic [REQUESTERS-1:0] grant_s;
  logic                  g0_valid_s, g1_valid_s;
  logic [PTR_W-1:0]      g0_idx_s, g1_idx_s;
  logic [PTR_W-1:0]      scan_idx_s;
  logic [PTR_W:0]        sum_s;
  logic                  b0_tag_s, b1_tag_s;
  logic [REG_BITS-1:0]   b0_arn_s, b1_arn_s, b0_rrn_s, b1_rrn_s;
  logic [XLEN-1:0]       b0_res_s, b1_res_s;

  logic [1:0]            bus_valid_r, bus_tag_r;
  logic [2*REG_BITS-1:0] bus_arn_r, bus_rrn_r;
  logic [2*XLEN-1:0]     bus_result_r;

  assign elig_s = req_valid & ~({REQUESTERS{delete_tag}} & req_tag);

  // Scan from ptr with wrap-around; first two eligible requesters win bus 0 and bus 1.
  always_comb begin
    g0_valid_s = 1'b0;
    g1_valid_s = 1'b0;
    g0_idx_s   = '0;
    g1_idx_s   = '0;
    scan_idx_s = '0;
    sum_s      = '0;
    for (int off = 0; off < REQUESTERS; off++) begin
      sum_s = {1'b0, ptr_r} + (PTR_W+1)'(off);
      if (sum_s >= (PTR_W+1)'(REQUESTERS)) begin
        sum_s = sum_s - (PTR_W+1)'(REQUESTERS);
      end else begin
        sum_s = sum_s;
      end
      scan_idx_s = sum_s[PTR_W-1:0];
      if (elig_s[scan_idx_s]) begin
        if (!g0_valid_s) begin
          g0_valid_s = 1'b1;
          g0_idx_s   = scan_idx_s;
        end else if (!g1_valid_s) begin
          g1_valid_s = 1'b1;
          g1_idx_s   = scan_idx_s;
        end else begin
          g1_valid_s = g1_valid_s;
        end
      end else begin
        g0_valid_s = g0_valid_s;
      end
    end
  end

  // Grant vector and the payload multiplexers for each bus.
  always_comb begin
    grant_s  = '0;
    b0_tag_s = 1'b0;
    b1_tag_s = 1'b0;
    b0_arn_s = '0;
    b1_arn_s = '0;
    b0_rrn_s = '0;
    b1_rrn_s = '0;
    b0_res_s = '0;
    b1_res_s = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (g0_valid_s && (g0_idx_s == PTR_W'(i))) begin
        grant_s[i] = 1'b1;
        b0_tag_s   = req_tag[i];
        b0_arn_s   = req_arn[i*REG_BITS +: REG_BITS];
        b0_rrn_s   = req_rrn[i*REG_BITS +: REG_BITS];
        b0_res_s   = req_result[i*XLEN +: XLEN];
      end else begin
        b0_tag_s = b0_tag_s;
      end
      if (g1_valid_s && (g1_idx_s == PTR_W'(i))) begin
        grant_s[i] = 1'b1;
        b1_tag_s   = req_tag[i];
        b1_arn_s   = req_arn[i*REG_BITS +: REG_BITS];
        b1_rrn_s   = req_rrn[i*REG_BITS +: REG_BITS];
        b1_res_s   = req_result[i*XLEN +: XLEN];
      end else begin
        b1_tag_s = b1_tag_s;
      end
    end
  end

  // Next pointer: one past the last granted requester, modulo REQUESTERS.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (g1_valid_s) begin
      ptr_nxt_s = g1_idx_s;
    end else if (g0_valid_s) begin
      ptr_nxt_s = g0_idx_s;
    end else begin
      ptr_nxt_s = ptr_r;
    end
    if (ptr_nxt_s == PTR_W'(REQUESTERS-1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_nxt_s + PTR_W'(1);
    end
  end

  // Pointer and bus registers; ungranted buses drop valid but keep their data fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r        <= '0;
      bus_valid_r  <= 2'b00;
      bus_tag_r    <= 2'b00;
      bus_arn_r    <= '0;
      bus_rrn_r    <= '0;
      bus_result_r <= '0;
    end else begin
      bus_valid_r <= {g1_valid_s, g0_valid_s};
      if (g0_valid_s) begin
        ptr_r                       <= ptr_nxt_s;
        bus_tag_r[0]                <= b0_tag_s;
        bus_arn_r[0 +: REG_BITS]    <= b0_arn_s;
        bus_rrn_r[0 +: REG_BITS]    <= b0_rrn_s;
        bus_result_r[0 +: XLEN]     <= b0_res_s;
      end
      if (g1_valid_s) begin
        bus_tag_r[1]                <= b1_tag_s;
        bus_arn_r[REG_BITS +: REG_BITS] <= b1_arn_s;
        bus_rrn_r[REG_BITS +: REG_BITS] <= b1_rrn_s;
        bus_result_r[XLEN +: XLEN]  <= b1_res_s;
      end
    end
  end

  // Grants are combinational so a requester sees ready in its request cycle.
  assign req_ready  = grant_s & {REQUESTERS{reset}};
  assign bus_valid  = bus_valid_r;
  assign bus_tag    = bus_tag_r;
  assign bus_arn    = bus_arn_r;
  assign bus_rrn    = bus_rrn_r;
  assign bus_result = bus_result_r;

`ifdef CDB_ARBITER_STALL_COUNT_EN
  logic [15:0] stall_cnt_r [REQUESTERS];

  // Saturating wait counters; flush-blocked cycles count as stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        stall_cnt_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (grant_s[i]) begin
          stall_cnt_r[i] <= 16'd0;
        end else if (req_valid[i] && (stall_cnt_r[i] != 16'hFFFF)) begin
          stall_cnt_r[i] <= stall_cnt_r[i] + 16'd1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_stall_out
    assign stall_count[gi*16 +: 16] = stall_cnt_r[gi];
  end
`else
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (REQUESTERS=4, XLEN=32, REG_BITS=6).
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic        delete_tag;
  logic [3:0]  req_valid;
  logic [3:0]  req_tag;
  logic [23:0] req_arn;
  logic [23:0] req_rrn;
  logic [127:0] req_result;
  logic [3:0]  req_ready;
  logic [1:0]  bus_valid;
  logic [1:0]  bus_tag;
  logic [11:0] bus_arn;
  logic [11:0] bus_rrn;
  logic [63:0] bus_result;
`ifdef CDB_ARBITER_STALL_COUNT_EN
  logic [63:0] stall_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cdb_arbiter #(.REQUESTERS(4), .XLEN(32), .REG_BITS(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .delete_tag (delete_tag),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_arn    (req_arn),
    .req_rrn    (req_rrn),
    .req_result (req_result),
    .req_ready  (req_ready),
    .bus_valid  (bus_valid),
    .bus_tag    (bus_tag),
    .bus_arn    (bus_arn),
    .bus_rrn    (bus_rrn),
`ifdef CDB_ARBITER_STALL_COUNT_EN
    .bus_result (bus_result),
    .stall_count(stall_count)
`else
    .bus_result (bus_result)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a request pattern, check the same-cycle grant, then advance past the edge.
  task automatic cycle(input string tag, input logic [3:0] v, input logic [3:0] t,
                       input logic dt, input logic [3:0] exp_ready);
    req_valid  = v;
    req_tag    = t;
    delete_tag = dt;
    #1;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clock);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic [1:0] v,
                           input logic [5:0] rrn0, input logic [5:0] rrn1);
    check_eq({tag, "_bvalid"}, 64'(bus_valid), 64'(v));
    check_eq({tag, "_rrn0"},   64'(bus_rrn[5:0]),  64'(rrn0));
    check_eq({tag, "_rrn1"},   64'(bus_rrn[11:6]), 64'(rrn1));
  endtask

  initial begin
    reset      = 1'b0;
    delete_tag = 1'b0;
    req_valid  = 4'b0000;
    req_tag    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_rrn[i*6 +: 6]      = 6'(10 + i);
      req_arn[i*6 +: 6]      = 6'(20 + i);
      req_result[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    req_valid = 4'b1111;
    #12;
    check_eq("rst_ready",  64'(req_ready),  64'd0);
    check_eq("rst_bvalid", 64'(bus_valid),  64'd0);
    check_eq("rst_rrn",    64'(bus_rrn),    64'd0);
    check_eq("rst_result", 64'(bus_result), 64'd0);
    req_valid = 4'b0000;
    @(posedge clock); #1;
    reset = 1'b1;

    // Single request, rrn=5, DEADBEEF on requester 0.
    req_rrn[5:0]     = 6'd5;
    req_result[31:0] = 32'hDEAD_BEEF;
    cycle("single", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    check_bus("single", 2'b01, 6'd5, 6'd0);
    check_eq("single_res0", 64'(bus_result[31:0]), 64'hDEAD_BEEF);
    check_eq("single_arn0", 64'(bus_arn[5:0]), 64'd20);
    req_rrn[5:0]     = 6'd10;
    req_result[31:0] = 32'hA000_0000;

    // ptr=1 now: lone requester 3 wraps ptr back to 0.
    cycle("r3", 4'b1000, 4'b0000, 1'b0, 4'b1000);
    check_bus("r3", 2'b01, 6'd13, 6'd0);

    // All valid from ptr=0: {0,1}, {2,3}, {0,1}.
    cycle("all_a", 4'b1111, 4'b0000, 1'b0, 4'b0011);
    check_bus("all_a", 2'b11, 6'd10, 6'd11);
    check_eq("all_a_res1", 64'(bus_result[63:32]), 64'hA000_0001);
    cycle("all_b", 4'b1111, 4'b0000, 1'b0, 4'b1100);
    check_bus("all_b", 2'b11, 6'd12, 6'd13);
    cycle("all_c", 4'b1111, 4'b0000, 1'b0, 4'b0011);
    check_bus("all_c", 2'b11, 6'd10, 6'd11);

    // ptr=2 -> grant 2 alone, ptr=3; then wrap-around 1001.
    cycle("r2", 4'b0100, 4'b0000, 1'b0, 4'b0100);
    check_bus("r2", 2'b01, 6'd12, 6'd11);
    cycle("wrap", 4'b1001, 4'b0000, 1'b0, 4'b1001);
    check_bus("wrap", 2'b11, 6'd13, 6'd10);
    cycle("ptr1", 4'b1111, 4'b0000, 1'b0, 4'b0110);
    check_bus("ptr1", 2'b11, 6'd11, 6'd12);

    // Flush blocks speculative requester 0; bus 1 data fields hold.
    cycle("flush", 4'b0011, 4'b0001, 1'b1, 4'b0010);
    check_bus("flush", 2'b01, 6'd11, 6'd12);
    check_eq("flush_tag", 64'(bus_tag), 64'd0);

    // Idle cycle: valids drop, data holds.
    cycle("idle", 4'b0000, 4'b0000, 1'b0, 4'b0000);
    check_bus("idle", 2'b00, 6'd11, 6'd12);

    // Speculative result without flush is granted and broadcast with tag.
    cycle("spec", 4'b0100, 4'b0100, 1'b0, 4'b0100);
    check_bus("spec", 2'b01, 6'd12, 6'd12);
    check_eq("spec_tag", 64'(bus_tag[0]), 64'd1);

    // Full load from ptr=3, then asynchronous reset mid-broadcast.
    cycle("pre_rst", 4'b1111, 4'b0000, 1'b0, 4'b1001);
    check_bus("pre_rst", 2'b11, 6'd13, 6'd10);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_bvalid", 64'(bus_valid), 64'd0);
    check_eq("async_ready",  64'(req_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    cycle("post_rst", 4'b1111, 4'b0000, 1'b0, 4'b0011);
    check_bus("post_rst", 2'b11, 6'd10, 6'd11);

`ifdef CDB_ARBITER_STALL_COUNT_EN
    reset = 1'b0;
    #1;
    check_eq("stall_rst", stall_count, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    cycle("st_a", 4'b1111, 4'b0000, 1'b0, 4'b0011);
    check_eq("stall3_a", 64'(stall_count[63:48]), 64'd1);
    check_eq("stall2_a", 64'(stall_count[47:32]), 64'd1);
    check_eq("stall0_a", 64'(stall_count[15:0]),  64'd0);
    cycle("st_b", 4'b1111, 4'b0000, 1'b0, 4'b1100);
    check_eq("stall3_b", 64'(stall_count[63:48]), 64'd0);
    check_eq("stall0_b", 64'(stall_count[15:0]),  64'd1);
`endif

    req_valid = 4'b0000;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common data buses between the execution units' result ports.
- Each cycle, grants up to two valid requesters in round-robin order and drives their results onto bus 0 / bus 1 one cycle later.
- Reservation stations, the register file and the ROB snoop the buses.
- Honours delete_tag flush by refusing and dropping speculative (tag=1) results.

Parameters:
- REQUESTERS, 4, number of execution-unit result ports; legal range 2..8.
- XLEN, 32, result data width; matches global_variables::XLEN.
- REG_BITS, 6, width of the arn/rrn register tags.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- delete_tag  in  1  flush speculative (tag=1) work this cycle.
- req_valid  in  REQUESTERS  per requester: result available.
- req_tag  in  REQUESTERS  per requester: result is speculative.
- req_arn  in  REQUESTERS*REG_BITS  architectural destination, requester i at slice [i*REG_BITS +: REG_BITS].
- req_rrn  in  REQUESTERS*REG_BITS  renamed destination, same slicing.
- req_result  in  REQUESTERS*XLEN  result data, slice [i*XLEN +: XLEN].
- req_ready  out  REQUESTERS  per requester: granted this cycle.
- bus_valid  out  2  per bus: broadcast valid.
- bus_tag  out  2  per bus: speculative flag of the broadcast.
- bus_arn  out  2*REG_BITS  per-bus arn.
- bus_rrn  out  2*REG_BITS  per-bus rrn.
- bus_result  out  2*XLEN  per-bus result.

Behaviour:
- Reset (reset=0, asynchronous):
  - ptr=0.
  - bus_valid, bus_tag, bus_arn, bus_rrn, bus_result all 0.
  - req_ready=0 while reset is held.
- Eligibility: req_valid[i] && !(delete_tag && req_tag[i]).
- Grant (combinational):
  - Scan indices ptr, ptr+1, ..., ptr+REQUESTERS-1, all mod REQUESTERS.
  - The first eligible requester gets bus 0; the second gets bus 1.
  - At most 2 grants per cycle; req_ready[i]=1 only for granted requesters.
- Handshake:
  - A transfer occurs when req_valid && req_ready.
  - The requester must hold valid and data stable until ready.
  - Ungranted requests wait; this block keeps no internal request storage.
- Latency: the granted result appears on the bus outputs exactly 1 cycle after the grant cycle. The bus registers load on the grant edge.
- Bus registers, every cycle:
  - Bus k with a grant loads valid=1 plus the tag/arn/rrn/result of its requester.
  - Bus k without a grant loads valid=0; data fields keep their old values.
  - A single grant always goes to bus 0; bus 1 is then valid=0.
- Pointer update:
  - With at least one grant: ptr <= (index of last granted requester + 1) mod REQUESTERS.
  - With no grant: ptr holds.
- Fairness: a continuously valid requester is granted within ceil(REQUESTERS/2) cycles.
- Flush:
  - While delete_tag=1, tag=1 requests are never granted.
  - tag=0 requests arbitrate normally in the same cycle.
  - A tag=1 entry already on the bus outputs still broadcasts for its cycle; consumers discard it using delete_tag.
- Wrap-around: with ptr=REQUESTERS-1, the scan continues at index 0.
- Simultaneous events: all REQUESTERS valid gives exactly 2 grants per cycle, rotating.
- Reset mid-operation: in-flight bus contents are lost; an ungranted requester must re-present after reset is released.

Optional Feature:
- Macro: CDB_ARBITER_STALL_COUNT_EN.
- Defined:
  - Adds output stall_count (REQUESTERS*16 bits): one saturating 16-bit counter per requester.
  - A counter increments each cycle its requester is valid but not granted (flush-blocked cycles included).
  - The counter clears to 0 on the cycle the requester is granted, and on reset.
  - Saturates at 16'hFFFF.
- Undefined: the port and its counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0001, rrn=6'd5, result=32'hDEAD_BEEF -> req_ready=4'b0001 in the same cycle; next cycle bus_valid=2'b01, bus 0 rrn=5, result=DEADBEEF; bus 1 invalid.
- req_valid=4'b1111 held with ptr=0 -> grants {0,1}, then {2,3}, then {0,1}; bus 0/bus 1 carry the matching rrns one cycle after each grant.
- ptr=3, req_valid=4'b1001 -> bus 0 gets requester 3, bus 1 gets requester 0; ptr becomes 1.
- delete_tag=1, req_valid=4'b0011, req_tag=4'b0001 -> only requester 1 is granted, on bus 0; requester 0's req_ready=0.
- reset pulled low mid-broadcast with bus_valid=2'b11 -> bus_valid=0 immediately (asynchronous); ptr=0 after release.
- With CDB_ARBITER_STALL_COUNT_EN defined and all 4 requesters valid: requester 3's count reads 1 at the cycle it is granted, then returns to 0.
